// File: rtl/pipe_pkg.sv
// Shared types and defaults for the ID->EX skid stage.
// Control-bundle field offsets are listed MSB first.
package pipe_pkg;

    localparam int CTRL_W_DEF = 12;
    localparam int DATA_W_DEF = 111;
    localparam int PC_W_DEF   = 32;

    localparam logic [PC_W_DEF-1:0] BUBBLE_PC_DEF = '1;

    localparam int CTRL_REGWRITE  = 11;
    localparam int CTRL_MEMTOREG  = 10;
    localparam int CTRL_MEMWRITE  = 9;
    localparam int CTRL_BRANCH    = 8;
    localparam int CTRL_ALUCTL_LSB = 4;
    localparam int CTRL_ALUCTL_W  = 4;
    localparam int CTRL_ALUSRC    = 3;
    localparam int CTRL_ALUSRC_SH = 2;
    localparam int CTRL_REGDST    = 1;
    localparam int CTRL_SPARE     = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        MAIN  = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/id_ex_skid_stage_if.sv
// ID->EX handshake bundle: ID-side input channel and EX-side output channel.
// master = surrounding pipeline, slave = the skid stage.
interface id_ex_skid_stage_if
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int PC_W   = PC_W_DEF
) ();

    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic [PC_W-1:0]   in_pc;

    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [PC_W-1:0]   out_pc;

    modport master (
        output in_valid, in_ctrl, in_data, in_pc, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, out_pc
    );

    modport slave (
        input  in_valid, in_ctrl, in_data, in_pc, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, out_pc
    );

endinterface

// File: rtl/id_ex_skid_stage.sv
// ID->EX pipeline register with 2-entry skid buffer and registered in_ready.
// Optional stall/flush counters: define ID_EX_SKID_STATS_EN.
module id_ex_skid_stage
    import pipe_pkg::*;
#(
    parameter int              CTRL_W    = CTRL_W_DEF,
    parameter int              DATA_W    = DATA_W_DEF,
    parameter int              PC_W      = PC_W_DEF,
    parameter logic [PC_W-1:0] BUBBLE_PC = '1
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     flush,
`ifdef ID_EX_SKID_STATS_EN
    output logic [31:0]              stall_cnt,
    output logic [15:0]              flush_cnt,
`endif
    id_ex_skid_stage_if.slave        bus
);

    skid_state_e       state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [PC_W-1:0]   main_pc_q, main_pc_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [PC_W-1:0]   skid_pc_q, skid_pc_d;

    logic out_valid;
    logic accept;
    logic drain;

    assign out_valid = (state_q != EMPTY);
    assign accept    = bus.in_valid & in_ready_q;
    assign drain     = out_valid & bus.out_ready;

    // Next-state and payload movement; flush wins over accept/drain.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        main_pc_d   = main_pc_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        skid_pc_d   = skid_pc_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d     = MAIN;
                    main_ctrl_d = bus.in_ctrl;
                    main_data_d = bus.in_data;
                    main_pc_d   = bus.in_pc;
                end
            end
            MAIN: begin
                if (accept && drain) begin
                    main_ctrl_d = bus.in_ctrl;
                    main_data_d = bus.in_data;
                    main_pc_d   = bus.in_pc;
                end else if (accept) begin
                    state_d     = FULL;
                    skid_ctrl_d = bus.in_ctrl;
                    skid_data_d = bus.in_data;
                    skid_pc_d   = bus.in_pc;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    state_d     = MAIN;
                    main_ctrl_d = skid_ctrl_q;
                    main_data_d = skid_data_q;
                    main_pc_d   = skid_pc_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
        in_ready_d = (state_d != FULL);
    end

    // State and payload registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            main_pc_q   <= BUBBLE_PC;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_pc_q   <= BUBBLE_PC;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            main_pc_q   <= main_pc_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.out_ctrl  = out_valid ? main_ctrl_q : '0;
    assign bus.out_pc    = out_valid ? main_pc_q : BUBBLE_PC;
    assign bus.out_data  = main_data_q;

`ifdef ID_EX_SKID_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Saturating stall and flush event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid && !bus.out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Directed self-checking bench for id_ex_skid_stage.
// Define ID_EX_SKID_STATS_EN to also exercise the counters.
module tb_id_ex_skid_stage;
    import pipe_pkg::*;

    localparam int CW = 12;
    localparam int DW = 111;
    localparam int PW = 32;
    localparam logic [PW-1:0] BUB = 32'hFFFF_FFFF;

    logic CLK = 1'b0;
    logic RESET;
    logic flush;
`ifdef ID_EX_SKID_STATS_EN
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    id_ex_skid_stage_if #(.CTRL_W(CW), .DATA_W(DW), .PC_W(PW)) bus ();

    id_ex_skid_stage #(
        .CTRL_W(CW), .DATA_W(DW), .PC_W(PW), .BUBBLE_PC(BUB)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .flush(flush),
`ifdef ID_EX_SKID_STATS_EN
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt),
`endif
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [CW-1:0] ctrl_of(input logic [PW-1:0] pc);
        return CW'(pc * 3 + 1);
    endfunction

    function automatic logic [DW-1:0] data_of(input logic [PW-1:0] pc);
        return {47'(pc ^ 32'h5A5A), 32'hDEAD_BEEF, pc};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic v, input logic [PW-1:0] pc);
        bus.in_valid = v;
        bus.in_pc    = pc;
        bus.in_ctrl  = ctrl_of(pc);
        bus.in_data  = data_of(pc);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        send(1'b0, 32'h0);
        tick();
        tick();
        checks++;
        if ({bus.out_valid, bus.out_pc, bus.out_ctrl, bus.out_data, bus.in_ready}
            !== {1'b0, BUB, 12'h0, 111'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_vals: got v=%b pc=%h c=%h d=%h r=%b",
                     bus.out_valid, bus.out_pc, bus.out_ctrl, bus.out_data, bus.in_ready);
        end
        RESET = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.out_valid, bus.out_pc, bus.out_ctrl, bus.in_ready}
            !== {1'b0, BUB, 12'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_idle: got v=%b pc=%h c=%h r=%b exp 0/ffffffff/000/1",
                     bus.out_valid, bus.out_pc, bus.out_ctrl, bus.in_ready);
        end
    endtask

    task automatic test_stream();
        logic [PW-1:0] pc;
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            pc = PW'(4 * i);
            send(1'b1, pc);
            tick();
            checks++;
            if ({bus.out_valid, bus.out_pc, bus.out_ctrl, bus.out_data, bus.in_ready}
                !== {1'b1, pc, ctrl_of(pc), data_of(pc), 1'b1}) begin
                errors++;
                $display("FAIL stream_%0d: got v=%b pc=%h c=%h r=%b exp pc=%h c=%h",
                         i, bus.out_valid, bus.out_pc, bus.out_ctrl, bus.in_ready,
                         pc, ctrl_of(pc));
            end
        end
        send(1'b0, 32'h0);
        tick();
        checks++;
        if ({bus.out_valid, bus.out_pc, bus.out_ctrl, bus.in_ready}
            !== {1'b0, BUB, 12'h0, 1'b1}) begin
            errors++;
            $display("FAIL stream_end: got v=%b pc=%h c=%h r=%b exp bubble",
                     bus.out_valid, bus.out_pc, bus.out_ctrl, bus.in_ready);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        send(1'b1, 32'd4);
        tick();
        checks++;
        if ({bus.out_valid, bus.out_pc, bus.in_ready} !== {1'b1, 32'd4, 1'b1}) begin
            errors++;
            $display("FAIL bp_first: got v=%b pc=%h r=%b exp 1/4/1",
                     bus.out_valid, bus.out_pc, bus.in_ready);
        end
        send(1'b1, 32'd8);
        tick();
        checks++;
        if ({bus.out_valid, bus.out_pc, bus.out_ctrl, bus.in_ready}
            !== {1'b1, 32'd4, ctrl_of(32'd4), 1'b0}) begin
            errors++;
            $display("FAIL bp_full: got v=%b pc=%h c=%h r=%b exp 1/4/%h/0",
                     bus.out_valid, bus.out_pc, bus.out_ctrl, bus.in_ready, ctrl_of(32'd4));
        end
        send(1'b1, 32'd99);
        tick();
        checks++;
        if ({bus.out_valid, bus.out_pc, bus.in_ready} !== {1'b1, 32'd4, 1'b0}) begin
            errors++;
            $display("FAIL bp_hold: got v=%b pc=%h r=%b exp 1/4/0",
                     bus.out_valid, bus.out_pc, bus.in_ready);
        end
        send(1'b0, 32'h0);
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if ({bus.out_valid, bus.out_pc, bus.out_ctrl, bus.out_data, bus.in_ready}
            !== {1'b1, 32'd8, ctrl_of(32'd8), data_of(32'd8), 1'b1}) begin
            errors++;
            $display("FAIL bp_skid_out: got v=%b pc=%h c=%h r=%b exp 1/8/%h/1",
                     bus.out_valid, bus.out_pc, bus.out_ctrl, bus.in_ready, ctrl_of(32'd8));
        end
        tick();
        checks++;
        if ({bus.out_valid, bus.out_pc, bus.in_ready} !== {1'b0, BUB, 1'b1}) begin
            errors++;
            $display("FAIL bp_drained: got v=%b pc=%h r=%b exp 0/ffffffff/1",
                     bus.out_valid, bus.out_pc, bus.in_ready);
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        send(1'b1, 32'd4);
        tick();
        send(1'b1, 32'd8);
        tick();
        send(1'b1, 32'd12);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if ({bus.out_valid, bus.out_pc, bus.out_ctrl, bus.in_ready}
            !== {1'b0, BUB, 12'h0, 1'b1}) begin
            errors++;
            $display("FAIL flush_full: got v=%b pc=%h c=%h r=%b exp bubble",
                     bus.out_valid, bus.out_pc, bus.out_ctrl, bus.in_ready);
        end
        send(1'b0, 32'h0);
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if ({bus.out_valid, bus.out_pc} !== {1'b0, BUB}) begin
            errors++;
            $display("FAIL flush_nothing_left: got v=%b pc=%h exp 0/ffffffff",
                     bus.out_valid, bus.out_pc);
        end
        send(1'b1, 32'd20);
        tick();
        send(1'b1, 32'd24);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        send(1'b0, 32'h0);
        checks++;
        if ({bus.out_valid, bus.out_pc, bus.in_ready} !== {1'b0, BUB, 1'b1}) begin
            errors++;
            $display("FAIL flush_drain: got v=%b pc=%h r=%b exp 0/ffffffff/1",
                     bus.out_valid, bus.out_pc, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        send(1'b1, 32'd16);
        tick();
        checks++;
        if ({bus.out_valid, bus.out_pc} !== {1'b1, 32'd16}) begin
            errors++;
            $display("FAIL rst_mid_load: got v=%b pc=%h exp 1/10",
                     bus.out_valid, bus.out_pc);
        end
        send(1'b0, 32'h0);
        RESET = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if ({bus.out_valid, bus.out_pc, bus.out_ctrl, bus.out_data, bus.in_ready}
            !== {1'b0, BUB, 12'h0, 111'h0, 1'b1}) begin
            errors++;
            $display("FAIL rst_mid: got v=%b pc=%h c=%h d=%h r=%b",
                     bus.out_valid, bus.out_pc, bus.out_ctrl, bus.out_data, bus.in_ready);
        end
        RESET = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if ({bus.out_valid, bus.out_pc} !== {1'b0, BUB}) begin
            errors++;
            $display("FAIL rst_mid_after: got v=%b pc=%h exp 0/ffffffff",
                     bus.out_valid, bus.out_pc);
        end
    endtask

`ifdef ID_EX_SKID_STATS_EN
    task automatic test_stats();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        bus.out_ready = 1'b0;
        send(1'b1, 32'd40);
        tick();
        send(1'b0, 32'h0);
        for (int i = 0; i < 5; i++) tick();
        bus.out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if ({stall_cnt, flush_cnt} !== {32'd5, 16'd1}) begin
            errors++;
            $display("FAIL stats: got stall=%0d flush=%0d exp 5/1",
                     stall_cnt, flush_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_reset_mid();
`ifdef ID_EX_SKID_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
